// File: rtl/multdiv_pkg.sv
// Shared constants for the MULT/DIV unit: default operand width, FSM encodings, iteration count.
// Optional MULTU/DIVU support is enabled in mult_div_unit by defining MULTDIV_UNSIGNED_EN.
package multdiv_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ITER_COUNT     = DATA_W_DEFAULT;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

endpackage

// File: rtl/multdiv_signfix.sv
// Conditional two's-complement negate: magnitude extraction on entry and sign restore on exit.
module multdiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle MIPS MULT/DIV unit: shift-add multiplier and restoring divider, one bit per clock.
// Define MULTDIV_UNSIGNED_EN to add the is_unsigned port (MULTU/DIVU semantics).
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_mult,
  input  logic              start_div,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic              is_unsigned,
`endif
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);

  localparam int               ITERS     = DATA_W;
  localparam int               CNT_W     = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] acc_hi;
  logic [DATA_W-1:0] acc_lo;
  logic [DATA_W-1:0] opnd;
  logic              neg_q;
  logic              neg_r;
  logic              signed_op;

`ifdef MULTDIV_UNSIGNED_EN
  assign signed_op = ~is_unsigned;
`else
  assign signed_op = 1'b1;
`endif

  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;

  multdiv_signfix #(.W(DATA_W)) u_abs_a (
    .value  (A),
    .negate (signed_op & A[DATA_W-1]),
    .result (a_mag)
  );

  multdiv_signfix #(.W(DATA_W)) u_abs_b (
    .value  (B),
    .negate (signed_op & B[DATA_W-1]),
    .result (b_mag)
  );

  // Multiply step: {acc_hi, acc_lo} holds partial product over the remaining multiplier bits.
  logic [DATA_W:0]     mult_sum;
  logic [2*DATA_W-1:0] prod_next;
  logic [2*DATA_W-1:0] prod_fixed;

  assign mult_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
  assign prod_next = {mult_sum, acc_lo[DATA_W-1:1]};

  multdiv_signfix #(.W(2*DATA_W)) u_fix_prod (
    .value  (prod_next),
    .negate (neg_q),
    .result (prod_fixed)
  );

  // Divide step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  logic [DATA_W:0]   div_shift;
  logic              div_ge;
  logic [DATA_W-1:0] rem_next;
  logic [DATA_W-1:0] quo_next;
  logic [DATA_W-1:0] rem_fixed;
  logic [DATA_W-1:0] quo_fixed;

  assign div_shift = {acc_hi, acc_lo[DATA_W-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign rem_next  = div_ge ? (div_shift[DATA_W-1:0] - opnd) : div_shift[DATA_W-1:0];
  assign quo_next  = {acc_lo[DATA_W-2:0], div_ge};

  multdiv_signfix #(.W(DATA_W)) u_fix_quo (
    .value  (quo_next),
    .negate (neg_q),
    .result (quo_fixed)
  );

  multdiv_signfix #(.W(DATA_W)) u_fix_rem (
    .value  (rem_next),
    .negate (neg_r),
    .result (rem_fixed)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Multiply takes priority when both starts arrive together.
          if (start_mult) begin
            state    <= MULT;
            acc_hi   <= '0;
            acc_lo   <= b_mag;
            opnd     <= a_mag;
            neg_q    <= signed_op & (A[DATA_W-1] ^ B[DATA_W-1]);
            neg_r    <= 1'b0;
            count    <= '0;
            busy     <= 1'b1;
            div_zero <= 1'b0;
          end else if (start_div) begin
            if (B == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state    <= DIV;
              acc_hi   <= '0;
              acc_lo   <= a_mag;
              opnd     <= b_mag;
              neg_q    <= signed_op & (A[DATA_W-1] ^ B[DATA_W-1]);
              neg_r    <= signed_op & A[DATA_W-1];
              count    <= '0;
              busy     <= 1'b1;
              div_zero <= 1'b0;
            end
          end
        end
        MULT: begin
          acc_hi <= prod_next[2*DATA_W-1:DATA_W];
          acc_lo <= prod_next[DATA_W-1:0];
          count  <= count + 1'b1;
          if (count == LAST_ITER) begin
            HI    <= prod_fixed[2*DATA_W-1:DATA_W];
            LO    <= prod_fixed[DATA_W-1:0];
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DIV: begin
          acc_hi <= rem_next;
          acc_lo <= quo_next;
          count  <= count + 1'b1;
          if (count == LAST_ITER) begin
            HI    <= rem_fixed;
            LO    <= quo_fixed;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus random MULT/DIV against an arithmetic model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;
  logic        div_zero;
`ifdef MULTDIV_UNSIGNED_EN
  logic        is_unsigned = 1'b0;
`endif

  mult_div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
`ifdef MULTDIV_UNSIGNED_EN
    .is_unsigned(is_unsigned),
`endif
    .A          (A),
    .B          (B),
    .HI         (HI),
    .LO         (LO),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          issue;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  logic        done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Issue one operation for a single edge and push the model's expected completion.
  task automatic applyStimulus(input string name, input bit do_mult, input bit do_div,
                               input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sbv;
    longint p;
    longint q;
    longint r;
    @(negedge clk);
    A = a;
    B = b;
    start_mult = do_mult;
    start_div = do_div;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    e.name  = name;
    e.issue = cyc;
    e.dz    = 1'b0;
    e.lat   = 33;
    if (do_mult) begin
      p = sa * sbv;
      model_hi = p[63:32];
      model_lo = p[31:0];
    end else if (b == 32'd0) begin
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      q = sa / sbv;
      r = sa % sbv;
      model_hi = r[31:0];
      model_lo = q[31:0];
    end
    e.hi = model_hi;
    e.lo = model_lo;
    sb.push_back(e);
    @(negedge clk);
    start_mult = 1'b0;
    start_div = 1'b0;
  endtask

  task automatic waitIdle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkOutput("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  // Monitor: every done pulse pops one expectation and checks results and latency.
  always @(negedge clk) begin
    if (!reset && done) begin
      checkOutput("done_width", 64'(done_prev), 64'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput({mon_e.name, "_hi"}, 64'(HI), 64'(mon_e.hi));
        checkOutput({mon_e.name, "_lo"}, 64'(LO), 64'(mon_e.lo));
        checkOutput({mon_e.name, "_dz"}, 64'(div_zero), 64'(mon_e.dz));
        checkOutput({mon_e.name, "_lat"}, 64'(cyc - mon_e.issue), 64'(mon_e.lat));
        checkOutput({mon_e.name, "_busy"}, 64'(busy), 64'd0);
      end
    end
    done_prev = done;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          sel;
    int          op;

    reset = 1'b1;
    start_mult = 1'b0;
    start_div = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_hi", 64'(HI), 64'd0);
    checkOutput("rst_lo", 64'(LO), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_dz", 64'(div_zero), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus("mult_7x-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    checkOutput("mult_busy", 64'(busy), 64'd1);
    waitIdle();
    applyStimulus("div_-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    waitIdle();
    applyStimulus("div_by_zero", 1'b0, 1'b1, 32'd5, 32'd0);
    waitIdle();
    applyStimulus("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle();
    applyStimulus("both_starts", 1'b1, 1'b1, 32'h1234_5678, 32'hFFFF_0003);
    waitIdle();

    // A divide start arriving mid-multiply must be dropped.
    applyStimulus("mult_busy_start", 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0123);
    repeat (9) @(negedge clk);
    checkOutput("busy_cycle10", 64'(busy), 64'd1);
    A = 32'd100;
    B = 32'd3;
    start_div = 1'b1;
    @(negedge clk);
    start_div = 1'b0;
    waitIdle();
    repeat (40) @(negedge clk);

    // Reset in the middle of a divide aborts without a done pulse.
    applyStimulus("div_aborted", 1'b0, 1'b1, 32'd1000, 32'd7);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    model_hi = '0;
    model_lo = '0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_hi", 64'(HI), 64'd0);
    checkOutput("abort_lo", 64'(LO), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    repeat (40) @(negedge clk);
    applyStimulus("mult_2^16x2^16", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    waitIdle();

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) b = 32'hFFFF_FFFF;
      else if (sel == 2) a = 32'h8000_0000;
      else if (sel == 3) b = $urandom_range(1, 15);
      op = $urandom_range(0, 1);
      applyStimulus(op == 0 ? "rand_mult" : "rand_div", op == 0, op == 1, a, b);
      waitIdle();
    end

    repeat (5) @(negedge clk);
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
